// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory, redirect and IF/ID handshake bundle for if_stage
interface if_stage_if;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instruction;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   modport master (
      output imem_req_valid, imem_req_addr, id_valid, id_instruction, id_pc, id_pc_plus4,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, id_valid, id_instruction, id_pc, id_pc_plus4,
      output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/if_stage.sv
// if_stage: RV32I fetch stage, one outstanding imem request, IF/ID register plus one-entry skid; IF_MISALIGN_FAULT_EN adds fetch_fault
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic clk,
   input  logic rst,
`ifdef IF_MISALIGN_FAULT_EN
   output logic fetch_fault,
`endif
   if_stage_if.master bus
);
   localparam logic [1:0] REQ = 2'd0, WAIT = 2'd1, DROP = 2'd2;
   logic [1:0]  state;
   logic [31:0] pc, fetch_pc, skid_instr, skid_pc, target;
   logic        skid_valid, fault, accept, resp, consume;
   assign target = {bus.redirect_pc[31:2], 2'b00};
   assign bus.imem_req_valid = !rst && state == REQ && !skid_valid && !fault;
   assign bus.imem_req_addr = pc;
   assign accept = bus.imem_req_valid && bus.imem_req_ready;
   assign resp = state == WAIT && bus.imem_resp_valid;
   assign consume = bus.id_valid && bus.id_ready;
`ifdef IF_MISALIGN_FAULT_EN
   // a misaligned redirect target latches a sticky fault that halts fetching
   always_ff @(posedge clk or posedge rst)
      if (rst) fault <= 1'b0;
      else if (bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00) fault <= 1'b1;
   assign fetch_fault = fault;
`else
   logic unused_low;
   assign unused_low = ^bus.redirect_pc[1:0];
   assign fault = 1'b0;
`endif
   // request FSM and PC; an outstanding request hit by a redirect is drained in DROP
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= REQ;
         pc <= RESET_PC;
         fetch_pc <= RESET_PC;
      end else if (bus.redirect_valid) begin
         pc <= target;
         state <= state == REQ ? (accept ? DROP : REQ) : (bus.imem_resp_valid ? REQ : DROP);
      end else begin
         if (accept) begin
            fetch_pc <= pc;
            pc <= pc + 32'd4;
         end
         state <= accept ? WAIT : (state != REQ && bus.imem_resp_valid) ? REQ : state;
      end
   // IF/ID register with skid: responses go straight to IF/ID when it can move, else park in skid
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.id_valid <= 1'b0;
         bus.id_instruction <= 32'h0000_0013;
         bus.id_pc <= 32'd0;
         bus.id_pc_plus4 <= 32'd0;
         skid_valid <= 1'b0;
         skid_instr <= 32'd0;
         skid_pc <= 32'd0;
      end else if (bus.redirect_valid) begin
         bus.id_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (resp && (!bus.id_valid || bus.id_ready)) begin
         bus.id_valid <= 1'b1;
         bus.id_instruction <= bus.imem_resp_data;
         bus.id_pc <= fetch_pc;
         bus.id_pc_plus4 <= fetch_pc + 32'd4;
      end else if (resp) begin
         skid_valid <= 1'b1;
         skid_instr <= bus.imem_resp_data;
         skid_pc <= fetch_pc;
      end else if (consume) begin
         bus.id_valid <= skid_valid;
         skid_valid <= 1'b0;
         if (skid_valid) begin
            bus.id_instruction <= skid_instr;
            bus.id_pc <= skid_pc;
            bus.id_pc_plus4 <= skid_pc + 32'd4;
         end
      end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage with a memory model and an in-order delivery model
module tb_if_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   if_stage_if bus ();
`ifdef IF_MISALIGN_FAULT_EN
   logic fetch_fault;
   if_stage #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .fetch_fault(fetch_fault), .bus(bus));
`else
   if_stage #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   // memory model: one pending request answered lat cycles after acceptance
   bit pend, live;
   int cd, lat = 1;
   logic [31:0] pend_addr;
   // delivery model: next address the stage must request and next PC it must hand to decode
   logic [31:0] exp_addr, exp_pc;
   int occ;
   bit fault_exp;
   // stimulus controls
   bit ready = 1, id_rdy = 1, redir, redir_on_resp, redir_hit;
   logic [31:0] rpc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h00A0_0113 : {a[31:2], 2'b11} ^ 32'h0F0F_0000;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
      end
   endtask

   task automatic step();
      bit resp_v, rd, acc, cons;
      @(negedge clk);
      resp_v = pend && cd == 0;
      rd = redir_on_resp ? resp_v : redir;
      bus.imem_req_ready = ready;
      bus.imem_resp_valid = resp_v;
      bus.imem_resp_data = resp_v ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      bus.redirect_valid = rd;
      bus.redirect_pc = rpc;
      bus.id_ready = id_rdy;
      #1;
      chk("req_valid", {31'd0, bus.imem_req_valid}, {31'd0, !pend && occ < 2 && !fault_exp});
      if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_addr);
      chk("id_valid", {31'd0, bus.id_valid}, {31'd0, occ > 0});
      if (occ > 0) begin
         chk("id_pc", bus.id_pc, exp_pc);
         chk("id_instruction", bus.id_instruction, mem_word(exp_pc));
         chk("id_pc_plus4", bus.id_pc_plus4, exp_pc + 32'd4);
      end
`ifdef IF_MISALIGN_FAULT_EN
      chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, fault_exp});
`endif
      acc = bus.imem_req_valid && ready;
      cons = occ > 0 && id_rdy;
      if (cons) begin
         occ--;
         exp_pc += 32'd4;
      end
      if (resp_v) begin
         if (live) occ++;
         pend = 0;
      end else if (pend) cd--;
      if (acc) begin
         pend = 1;
         live = 1;
         cd = lat - 1;
         pend_addr = bus.imem_req_addr;
         exp_addr += 32'd4;
      end
      if (rd) begin
         occ = 0;
         live = 0;
         exp_addr = {rpc[31:2], 2'b00};
         exp_pc = exp_addr;
`ifdef IF_MISALIGN_FAULT_EN
         if (rpc[1:0] != 2'b00) fault_exp = 1;
`endif
         if (redir_on_resp) begin
            redir_hit = 1;
            redir_on_resp = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      bus.imem_resp_valid = 0;
      bus.redirect_valid = 0;
      bus.imem_req_ready = ready;
      bus.id_ready = id_rdy;
      pend = 0; live = 0; occ = 0; exp_addr = 0; exp_pc = 0; fault_exp = 0; redir = 0; redir_on_resp = 0;
      #1;
      chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
      chk("rst_id_instruction", bus.id_instruction, 32'h0000_0013);
      chk("rst_id_pc", bus.id_pc, 32'd0);
      chk("rst_id_pc_plus4", bus.id_pc_plus4, 32'd0);
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   task automatic wait_req(input int bound);
      int n = 0;
      while (!bus.imem_req_valid && n < bound) begin
         step();
         n++;
      end
      chk("wait_req", {31'd0, bus.imem_req_valid}, 32'd1);
   endtask

   task automatic wait_id(input int bound);
      int n = 0;
      while (!bus.id_valid && n < bound) begin
         step();
         n++;
      end
      chk("wait_id", {31'd0, bus.id_valid}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // in-order fetch with 1-cycle memory and decode always ready
      do_reset();
      step();
      chk("t1_id_valid_early", {31'd0, bus.id_valid}, 32'd0);
      step();
      chk("t1_pc0", bus.id_pc, 32'h0);
      chk("t1_instr0", bus.id_instruction, 32'h0050_0093);
      chk("t1_plus4_0", bus.id_pc_plus4, 32'h4);
      step();
      step();
      chk("t1_pc4", bus.id_pc, 32'h4);
      chk("t1_instr4", bus.id_instruction, 32'h00A0_0113);
      chk("t1_plus4_4", bus.id_pc_plus4, 32'h8);
      step();
      step();
      chk("t1_pc8", bus.id_pc, 32'h8);
      chk("t1_plus4_8", bus.id_pc_plus4, 32'hC);
      // backpressure: second word parks in skid and blocks further requests
      id_rdy = 0;
      do_reset();
      repeat (4) step();
      chk("t2_hold_pc", bus.id_pc, 32'h0);
      chk("t2_skid_blocks", {31'd0, bus.imem_req_valid}, 32'd0);
      repeat (2) step();
      chk("t2_still_blocked", {31'd0, bus.imem_req_valid}, 32'd0);
      id_rdy = 1;
      step();
      chk("t2_from_skid", bus.id_pc, 32'h4);
      chk("t2_req_resumes", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("t2_req_addr8", bus.imem_req_addr, 32'h8);
      // redirect while waiting on the fetch of 0x8
      lat = 3;
      step();
      redir = 1;
      rpc = 32'h100;
      step();
      redir = 0;
      chk("t3_id_flushed", {31'd0, bus.id_valid}, 32'd0);
      chk("t3_no_req_drop", {31'd0, bus.imem_req_valid}, 32'd0);
      wait_req(10);
      chk("t3_req_target", bus.imem_req_addr, 32'h100);
      wait_id(10);
      chk("t3_id_pc", bus.id_pc, 32'h100);
      // redirect coincident with a response
      lat = 2;
      rpc = 32'h200;
      redir_hit = 0;
      redir_on_resp = 1;
      for (int n = 0; n < 20 && !redir_hit; n++) step();
      chk("t4_redirect_hit", {31'd0, redir_hit}, 32'd1);
      chk("t4_id_flushed", {31'd0, bus.id_valid}, 32'd0);
      wait_req(10);
      chk("t4_req_target", bus.imem_req_addr, 32'h200);
      wait_id(10);
      chk("t4_id_pc", bus.id_pc, 32'h200);
      // memory stall: request held stable
      ready = 0;
      lat = 1;
      do_reset();
      for (int n = 0; n < 5; n++) begin
         step();
         chk("t5_hold_valid", {31'd0, bus.imem_req_valid}, 32'd1);
         chk("t5_hold_addr", bus.imem_req_addr, 32'h0);
      end
      ready = 1;
      wait_id(10);
      chk("t5_id_pc", bus.id_pc, 32'h0);
      // mixed traffic: varying latency, stalls, backpressure and aligned redirects
      for (int i = 0; i < 300; i++) begin
         lat = 1 + i % 3;
         ready = (i % 7) != 3;
         id_rdy = (i % 4) != 0 && (i % 11) < 8;
         redir = (i % 37) == 20;
         rpc = i * 64;
         step();
      end
      redir = 0;
      ready = 1;
      id_rdy = 1;
      lat = 1;
      // misaligned redirect
      do_reset();
      redir = 1;
      rpc = 32'h102;
      step();
      redir = 0;
`ifdef IF_MISALIGN_FAULT_EN
      chk("t6_fault", {31'd0, fetch_fault}, 32'd1);
      repeat (6) step();
      chk("t6_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("t6_no_id", {31'd0, bus.id_valid}, 32'd0);
`else
      wait_req(10);
      chk("t6_req_aligned", bus.imem_req_addr, 32'h100);
      wait_id(10);
      chk("t6_id_pc", bus.id_pc, 32'h100);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
